nsr_vec: RTL and testbench
==========================

NSR_VEC -- requirements
Module: nsr_vec

Interface
REQ-001 Parameter DW, default 32: width of one state word in bits.
REQ-002 Parameter DEPTH, default 32: number of state words; SHALL be a power of two and at least 16.
REQ-003 Parameter AW, default $clog2(DEPTH): address width.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 we  input  1  write request valid.
REQ-007 VL  input  2  vector length: 00=1 word, 01=4 words, 10=16 words, 11=illegal.
REQ-008 wa  input  AW  base write address.
REQ-009 wd  input  16*DW  write data; lane i is wd[DW*i +: DW].
REQ-010 ready  output  1  high when a request can be accepted.
REQ-011 done  output  1  one-cycle pulse: the last word of a request has committed.
REQ-012 err  output  1  one-cycle pulse: an illegal VL was accepted.
REQ-013 ra  input  AW  read address.
REQ-014 rd  output  DW  read data.

Function
REQ-015 A request SHALL transfer on a rising edge where we=1 and ready=1; we while ready=0 SHALL be ignored, and the requester holds we.
REQ-016 Word count N SHALL be 1, 4 or 16 for VL = 00, 01 or 10.
REQ-017 FSM states: IDLE, BURST. ready SHALL be 1 exactly when state=IDLE and rst=0.
REQ-018 The transfer edge SHALL write lane 0 to entry wa.
- N=1: the FSM stays in IDLE.
- N>1: the FSM goes to BURST, latching wd, wa and N.
REQ-019 In BURST, each edge SHALL write latched lane k to entry (base+k) mod DEPTH, for k=1..N-1, one lane per cycle. A 4-bit lane counter tracks k.
REQ-020 The edge that writes lane N-1 SHALL return the FSM to IDLE. A request therefore occupies N cycles; ready is low for cycles 2..N.
REQ-021 Address wrap: entries past DEPTH-1 wrap to 0. Example: wa=30, VL=01 writes entries 30, 31, 0, 1.
REQ-022 done SHALL be registered and high for exactly the one cycle after the edge that writes lane N-1.
REQ-023 Back-to-back requests: a new request MAY transfer in the cycle done is high. Throughput: one request per N cycles.
REQ-024 VL=11 accepted: no entry written, FSM stays IDLE, err high for the following cycle, done stays low.
REQ-025 Inputs wd, wa and VL are sampled only on the transfer edge; changes during BURST have no effect.
REQ-026 rd SHALL be combinational: the committed value of entry ra. There is no bypass, so a write is visible from the cycle after its edge. During BURST, rd reflects the lanes committed so far.
REQ-027 Lanes N..15 of wd SHALL be ignored.

Reset
REQ-028 rst=1 at an edge SHALL:
- clear all DEPTH entries to 0;
- force state=IDLE and zero the lane counter;
- drive done=0 and err=0 the next cycle.
REQ-029 ready SHALL be 0 while rst=1.
REQ-030 rst SHALL take priority over any write. A request presented with rst=1 is dropped.
REQ-031 rst during BURST aborts the burst: no further lanes are written, no done pulse is produced, and all entries read 0 afterwards.

Verification
REQ-032 Scalar write: wa=5, VL=00, lane0=0xDEADBEEF, we=1 one cycle -> next cycle rd(ra=5)=0xDEADBEEF, done=1 for one cycle, ready stays 1.
REQ-033 Wrap burst: wa=30, VL=01, lanes=0x11,0x22,0x33,0x44 ->
- ready low for cycles 2-4;
- done in cycle 5;
- entries 30, 31, 0, 1 read 0x11, 0x22, 0x33, 0x44;
- entry 2 unchanged.
REQ-034 Full burst: wa=0, VL=10, lane i=i+1, with wd changed to all-ones in cycle 2 -> entries 0-15 read 1-16, done exactly 16 cycles after transfer.
REQ-035 Illegal VL: VL=11, we=1 -> err=1 next cycle, done=0, all entries unchanged, ready stays 1.
REQ-036 Reset mid-burst: VL=10 burst, rst=1 in its cycle 6 -> no done, ready=1 the cycle after rst deasserts, all entries read 0.
REQ-037 Back-to-back: second VL=00 request to wa=7 in the done cycle of a VL=01 burst -> accepted, entry 7 written, done pulses in two consecutive cycles.

Source files
------------

// File: rtl/nsr_vec.sv
// Vector state register file: 1/4/16-word burst writes one lane per cycle, combinational read port.
// Throughput one request per N cycles; ready drops for the remainder of a burst.
module nsr_vec #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [1:0]        VL,
  input  logic [AW-1:0]     wa,
  input  logic [16*DW-1:0]  wd,
  output logic              ready,
  output logic              done,
  output logic              err,
  input  logic [AW-1:0]     ra,
  output logic [DW-1:0]     rd
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t             r_state, w_state_nxt;
  logic [3:0]         r_k, w_k_nxt;
  logic [3:0]         r_last;
  logic [AW-1:0]      r_base;
  logic [16*DW-1:0]   r_wd;
  logic [DW-1:0]      r_mem [DEPTH];
  logic               r_done, r_err;

  logic               w_load;
  logic               w_mem_we;
  logic [AW-1:0]      w_mem_addr;
  logic [DW-1:0]      w_mem_dat;
  logic               w_done_nxt;
  logic               w_err_nxt;

  assign ready = (r_state == S_IDLE) && !rst;
  assign done  = r_done;
  assign err   = r_err;
  assign rd    = r_mem[ra];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= 4'd0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_load      = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = wa;
    w_mem_dat   = wd[DW-1:0];
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (we) begin
          case (VL)
            2'b00: begin
              w_mem_we   = 1'b1;
              w_done_nxt = 1'b1;
            end
            2'b01, 2'b10: begin
              w_mem_we    = 1'b1;
              w_load      = 1'b1;
              w_k_nxt     = 4'd1;
              w_state_nxt = S_BURST;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      S_BURST: begin
        // Address arithmetic is truncated to AW bits, which gives the wrap for free.
        w_mem_we   = 1'b1;
        w_mem_addr = r_base + AW'(r_k);
        w_mem_dat  = r_wd[DW*r_k +: DW];
        w_k_nxt    = r_k + 4'd1;
        if (r_k == r_last) begin
          w_state_nxt = S_IDLE;
          w_k_nxt     = 4'd0;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && w_load) begin
      r_wd   <= wd;
      r_base <= wa;
      r_last <= (VL == 2'b01) ? 4'd3 : 4'd15;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_dat;
    end
  end

endmodule

// File: tb/tb_nsr_vec.sv
// Self-checking bench for nsr_vec: directed scenarios plus randomized bursts against an array model.
module tb_nsr_vec;
  localparam int DW    = 32;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH);

  logic              clk;
  logic              rst;
  logic              we;
  logic [1:0]        VL;
  logic [AW-1:0]     wa;
  logic [16*DW-1:0]  wd;
  logic              ready;
  logic              done;
  logic              err;
  logic [AW-1:0]     ra;
  logic [DW-1:0]     rd;

  logic [DW-1:0]     exp_mem [DEPTH];
  int                vectors;
  int                miscompares;

  nsr_vec #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .we(we), .VL(VL), .wa(wa), .wd(wd),
    .ready(ready), .done(done), .err(err), .ra(ra), .rd(rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (got hang, need $finish)");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic int vl_words(input logic [1:0] v);
    case (v)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 16;
      default: return 0;
    endcase
  endfunction

  // Reference: a request writes lane k to (base+k) mod DEPTH for k < N.
  task automatic model_write(input logic [1:0] v, input logic [AW-1:0] a, input logic [16*DW-1:0] d);
    int n;
    n = vl_words(v);
    for (int k = 0; k < n; k++) exp_mem[(int'(a) + k) % DEPTH] = d[DW*k +: DW];
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
  endtask

  task automatic rand_wd(output logic [16*DW-1:0] d);
    for (int i = 0; i < 16; i++) d[DW*i +: DW] = $urandom();
  endtask

  task automatic test_reset();
    rst = 1'b1; we = 1'b1; VL = 2'b00; wa = AW'(3); wd = '1; ra = '0;
    cyc();
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready got=%b need=0", ready); end
    cyc();
    vectors++;
    if (done !== 1'b0 || err !== 1'b0) begin
      miscompares++; $display("FAIL reset_flags got done=%b err=%b need 0 0", done, err);
    end
    rst = 1'b0; we = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after got=%b need=1", ready); end
    model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      ra = AW'(i); #1; vectors++;
      if (rd !== exp_mem[i]) begin miscompares++; $display("FAIL reset_entry[%0d] got=%h need=%h", i, rd, exp_mem[i]); end
    end
  endtask

  task automatic test_scalar();
    logic [16*DW-1:0] d;
    rand_wd(d);
    d[DW-1:0] = 32'hDEADBEEF;
    cyc();
    we = 1'b1; VL = 2'b00; wa = AW'(5); wd = d; ra = AW'(5);
    cyc();
    we = 1'b0; wd = '1;
    model_write(2'b00, AW'(5), d);
    vectors++;
    if (done !== 1'b1 || ready !== 1'b1 || rd !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL scalar got done=%b ready=%b rd=%h need 1 1 deadbeef", done, ready, rd);
    end
    cyc();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL scalar_done_pulse got=%b need=0", done); end
  endtask

  task automatic test_wrap_burst();
    logic [16*DW-1:0] d;
    rand_wd(d);
    d[DW*0 +: DW] = 32'h11; d[DW*1 +: DW] = 32'h22;
    d[DW*2 +: DW] = 32'h33; d[DW*3 +: DW] = 32'h44;
    we = 1'b1; VL = 2'b01; wa = AW'(30); wd = d; ra = AW'(30);
    cyc();
    we = 1'b0; rand_wd(wd); wa = AW'(2);
    model_write(2'b01, AW'(30), d);
    vectors++;
    if (rd !== 32'h11) begin miscompares++; $display("FAIL wrap_partial rd got=%h need=11", rd); end
    for (int c = 2; c <= 4; c++) begin
      vectors++;
      if (ready !== 1'b0 || done !== 1'b0) begin
        miscompares++; $display("FAIL wrap_cycle%0d got ready=%b done=%b need 0 0", c, ready, done);
      end
      cyc();
    end
    vectors++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      miscompares++; $display("FAIL wrap_done got done=%b ready=%b need 1 1", done, ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ra = AW'(i); #1; vectors++;
      if (rd !== exp_mem[i]) begin miscompares++; $display("FAIL wrap_entry[%0d] got=%h need=%h", i, rd, exp_mem[i]); end
    end
  endtask

  task automatic test_full_burst();
    logic [16*DW-1:0] d;
    int cyc_no;
    bit seen;
    for (int i = 0; i < 16; i++) d[DW*i +: DW] = DW'(i + 1);
    cyc();
    we = 1'b1; VL = 2'b10; wa = '0; wd = d;
    cyc();
    we = 1'b0; wd = '1; VL = 2'b00; wa = AW'(9);
    model_write(2'b10, '0, d);
    cyc_no = 2;
    seen = 1'b0;
    while (!seen && cyc_no < 40) begin
      if (done === 1'b1) seen = 1'b1;
      else begin cyc(); cyc_no++; end
    end
    vectors++;
    if (!seen || cyc_no != 17) begin
      miscompares++; $display("FAIL full_done_cycle got=%0d (seen=%0d) need=17", cyc_no, seen);
    end
    for (int i = 0; i < DEPTH; i++) begin
      ra = AW'(i); #1; vectors++;
      if (rd !== exp_mem[i]) begin miscompares++; $display("FAIL full_entry[%0d] got=%h need=%h", i, rd, exp_mem[i]); end
    end
  endtask

  task automatic test_illegal();
    cyc();
    we = 1'b1; VL = 2'b11; wa = AW'($urandom_range(0, DEPTH-1)); rand_wd(wd);
    cyc();
    we = 1'b0;
    vectors++;
    if (err !== 1'b1 || done !== 1'b0 || ready !== 1'b1) begin
      miscompares++; $display("FAIL illegal got err=%b done=%b ready=%b need 1 0 1", err, done, ready);
    end
    cyc();
    vectors++;
    if (err !== 1'b0) begin miscompares++; $display("FAIL illegal_err_pulse got=%b need=0", err); end
    for (int i = 0; i < DEPTH; i++) begin
      ra = AW'(i); #1; vectors++;
      if (rd !== exp_mem[i]) begin miscompares++; $display("FAIL illegal_entry[%0d] got=%h need=%h", i, rd, exp_mem[i]); end
    end
  endtask

  task automatic test_reset_mid_burst();
    int done_cnt;
    cyc();
    we = 1'b1; VL = 2'b10; wa = AW'($urandom_range(0, DEPTH-1)); rand_wd(wd);
    cyc();
    we = 1'b0;
    for (int c = 2; c < 6; c++) cyc();
    rst = 1'b1;
    #1;
    vectors++;
    if (ready !== 1'b0) begin miscompares++; $display("FAIL midrst_ready_in_rst got=%b need=0", ready); end
    cyc();
    rst = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      miscompares++; $display("FAIL midrst_after got ready=%b done=%b need 1 0", ready, done);
    end
    done_cnt = 0;
    for (int c = 0; c < 16; c++) begin cyc(); if (done === 1'b1) done_cnt++; end
    vectors++;
    if (done_cnt != 0) begin miscompares++; $display("FAIL midrst_no_done got=%0d pulses need=0", done_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      ra = AW'(i); #1; vectors++;
      if (rd !== exp_mem[i]) begin miscompares++; $display("FAIL midrst_entry[%0d] got=%h need=%h", i, rd, exp_mem[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [16*DW-1:0] d1, d2;
    rand_wd(d1); rand_wd(d2);
    cyc();
    we = 1'b1; VL = 2'b01; wa = AW'(20); wd = d1;
    cyc();
    model_write(2'b01, AW'(20), d1);
    we = 1'b0;
    cyc(); cyc(); cyc();
    vectors++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      miscompares++; $display("FAIL b2b_first_done got done=%b ready=%b need 1 1", done, ready);
    end
    we = 1'b1; VL = 2'b00; wa = AW'(7); wd = d2; ra = AW'(7);
    cyc();
    we = 1'b0;
    model_write(2'b00, AW'(7), d2);
    vectors++;
    if (done !== 1'b1 || rd !== exp_mem[7]) begin
      miscompares++; $display("FAIL b2b_second got done=%b rd=%h need 1 %h", done, rd, exp_mem[7]);
    end
    cyc();
    vectors++;
    if (done !== 1'b0) begin miscompares++; $display("FAIL b2b_done_end got=%b need=0", done); end
  endtask

  task automatic test_random();
    logic [16*DW-1:0] d;
    logic [1:0]       v;
    logic [AW-1:0]    a;
    int               n;
    int               idx;
    for (int r = 0; r < 40; r++) begin
      v = 2'($urandom_range(0, 3));
      a = AW'($urandom_range(0, DEPTH-1));
      rand_wd(d);
      n = vl_words(v);
      we = 1'b1; VL = v; wa = a; wd = d;
      cyc();
      we = 1'b0;
      model_write(v, a, d);
      for (int c = 1; c < n; c++) begin
        rand_wd(wd); VL = 2'($urandom_range(0, 3)); wa = AW'($urandom());
        vectors++;
        if (ready !== 1'b0 || done !== 1'b0) begin
          miscompares++; $display("FAIL rand%0d_busy c=%0d got ready=%b done=%b need 0 0", r, c, ready, done);
        end
        cyc();
      end
      vectors++;
      if (done !== (n > 0) || err !== (n == 0) || ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rand%0d_end vl=%0d got done=%b err=%b ready=%b need %0d %0d 1",
                 r, v, done, err, ready, n > 0, n == 0);
      end
      for (int j = 0; j < 4; j++) begin
        idx = (j == 0) ? int'(a) : int'($urandom_range(0, DEPTH-1));
        ra = AW'(idx); #1; vectors++;
        if (rd !== exp_mem[idx]) begin
          miscompares++; $display("FAIL rand%0d_entry[%0d] got=%h need=%h", r, idx, rd, exp_mem[idx]);
        end
      end
      cyc();
    end
    for (int i = 0; i < DEPTH; i++) begin
      ra = AW'(i); #1; vectors++;
      if (rd !== exp_mem[i]) begin miscompares++; $display("FAIL rand_final_entry[%0d] got=%h need=%h", i, rd, exp_mem[i]); end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b1; we = 1'b0; VL = 2'b00; wa = '0; wd = '0; ra = '0;
    test_reset();
    test_scalar();
    test_wrap_burst();
    test_full_burst();
    test_illegal();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
